vec_normalizer: RTL and testbench

VEC_NORMALIZER -- requirements
Module: vec_normalizer

---
 rtl/vec_norm_pkg.sv | 13 +
 rtl/norm_div_serial.sv | 45 ++++
 rtl/vec_normalizer.sv | 128 ++++++++++++
 tb/tb_vec_normalizer.sv | 133 +++++++++++++
 4 files changed

// File: rtl/vec_norm_pkg.sv
// vec_norm_pkg: FSM state type and width/latency helpers shared by vec_normalizer
package vec_norm_pkg;
   typedef enum logic [2:0] {IDLE, SQACC, SQRT, DIV, HOLD} state_t;
   function automatic int sumw_f(input int dw, input int n);
      return 2 * dw + $clog2(n);
   endfunction
   function automatic int rw_f(input int dw, input int n);
      return (sumw_f(dw, n) + 1) / 2;
   endfunction
   function automatic int lat_f(input int dw, input int n);
      return 1 + n + rw_f(dw, n) + n * dw;
   endfunction
endpackage

// File: rtl/norm_div_serial.sv
// norm_div_serial: DATAWIDTH-cycle restoring divider computing floor((x << FRAC_BITS) / d)
module norm_div_serial #(
   parameter int DATAWIDTH = 16,
   parameter int FRAC_BITS = 8,
   parameter int DIVW      = 17
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 i_start,
   input  logic [DATAWIDTH-1:0] i_x,
   input  logic [DIVW-1:0]      i_d,
   output logic                 o_done,
   output logic [DATAWIDTH-1:0] o_q
);
   localparam int CW = $clog2(DATAWIDTH);
   logic [DIVW-1:0]      r_rem, w_rem_in, w_rem_next;
   logic [DATAWIDTH-1:0] r_sr, w_sr_in;
   logic [CW-1:0]        r_cnt;
   logic                 r_busy;
   logic [DIVW:0]        w_trial;
   logic                 w_ge;
   // d >= x, so the quotient fits DATAWIDTH bits and the top FRAC_BITS of the dividend seed the remainder
   always_comb begin
      w_rem_in   = i_start ? DIVW'(i_x >> (DATAWIDTH - FRAC_BITS)) : r_rem;
      w_sr_in    = i_start ? i_x << FRAC_BITS : r_sr;
      w_trial    = {w_rem_in, w_sr_in[DATAWIDTH-1]};
      w_ge       = w_trial >= {1'b0, i_d};
      w_rem_next = w_ge ? DIVW'(w_trial - {1'b0, i_d}) : w_trial[DIVW-1:0];
   end
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         r_rem  <= '0;
         r_sr   <= '0;
         r_cnt  <= '0;
         r_busy <= 1'b0;
      end else if (i_start || (r_busy && r_cnt != '0)) begin
         r_rem  <= w_rem_next;
         r_sr   <= {w_sr_in[DATAWIDTH-2:0], w_ge};
         r_cnt  <= i_start ? CW'(DATAWIDTH - 1) : r_cnt - 1'b1;
         r_busy <= 1'b1;
      end else
         r_busy <= 1'b0;
   assign o_done = r_busy && r_cnt == '0;
   assign o_q    = r_sr;
endmodule

// File: rtl/vec_normalizer.sv
// vec_normalizer: serial L2 normalisation of an unsigned fixed-point vector with fixed latency
module vec_normalizer
   import vec_norm_pkg::*;
#(
   parameter int DATAWIDTH    = 16,
   parameter int FRAC_BITS    = 8,
   parameter int NUM_CHANNELS = 4,
   parameter int INSTANCE_ID  = 0
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic                                  i_valid,
   output logic                                  i_ready,
   input  logic [NUM_CHANNELS*DATAWIDTH-1:0]     i_data,
   output logic                                  o_valid,
   input  logic                                  o_ready,
   output logic [NUM_CHANNELS*DATAWIDTH-1:0]     o_data,
   output logic [rw_f(DATAWIDTH, NUM_CHANNELS)-1:0] o_norm,
   output logic                                  o_zero
);
   localparam int SUMW = sumw_f(DATAWIDTH, NUM_CHANNELS);
   localparam int RW   = rw_f(DATAWIDTH, NUM_CHANNELS);
   localparam int SQW  = 2 * RW;
   localparam int CW   = $clog2(NUM_CHANNELS * DATAWIDTH + RW + 2);
   localparam int CHW  = $clog2(NUM_CHANNELS);
   if (NUM_CHANNELS < 2 || NUM_CHANNELS > 32 || FRAC_BITS >= DATAWIDTH || INSTANCE_ID < 0) begin : g_param_chk
      $error("vec_normalizer: illegal parameter set");
   end
   state_t                          r_state;
   logic [NUM_CHANNELS*DATAWIDTH-1:0] r_vec, r_data;
   logic [SUMW-1:0]                 r_acc, w_acc_next;
   logic [SQW-1:0]                  r_sq;
   logic [RW-1:0]                   r_rem, r_root, r_norm;
   logic [RW+1:0]                   w_rem_sh, w_trial;
   logic [CW-1:0]                   r_cnt;
   logic [CHW-1:0]                  r_ch, w_idx;
   logic [DATAWIDTH-1:0]            w_x, w_q;
   logic [2*DATAWIDTH-1:0]          w_sqr;
   logic                            r_zero, r_valid, r_ozero, w_ge, w_start, w_done;
   // the divider is restarted on the same edge it finishes, so the next channel is selected early
   always_comb begin
      w_idx      = (r_state == DIV && w_done) ? r_ch + 1'b1 : r_ch;
      w_x        = r_vec[w_idx*DATAWIDTH +: DATAWIDTH];
      w_sqr      = w_x * w_x;
      w_acc_next = r_acc + SUMW'(w_sqr);
      w_rem_sh   = {r_rem, r_sq[SQW-1 -: 2]};
      w_trial    = {r_root, 2'b01};
      w_ge       = w_rem_sh >= w_trial;
      w_start    = r_state == DIV && !r_zero &&
                   (r_cnt == '0 || (w_done && r_ch != CHW'(NUM_CHANNELS - 1)));
   end
   norm_div_serial #(.DATAWIDTH(DATAWIDTH), .FRAC_BITS(FRAC_BITS), .DIVW(RW)) u_div (
      .clk(clk), .rst(rst), .i_start(w_start), .i_x(w_x), .i_d(r_root), .o_done(w_done), .o_q(w_q)
   );
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         r_state <= IDLE;
         r_vec   <= '0;
         r_acc   <= '0;
         r_sq    <= '0;
         r_rem   <= '0;
         r_root  <= '0;
         r_cnt   <= '0;
         r_ch    <= '0;
         r_zero  <= 1'b0;
         r_valid <= 1'b0;
         r_data  <= '0;
         r_norm  <= '0;
         r_ozero <= 1'b0;
      end else
         case (r_state)
            IDLE: if (i_valid) begin
               r_state <= SQACC;
               r_vec   <= i_data;
               r_acc   <= '0;
               r_ch    <= '0;
               r_data  <= '0;
               r_norm  <= '0;
               r_ozero <= 1'b0;
            end
            SQACC: begin
               r_acc <= w_acc_next;
               r_ch  <= r_ch + 1'b1;
               if (r_ch == CHW'(NUM_CHANNELS - 1)) begin
                  r_state <= SQRT;
                  r_ch    <= '0;
                  r_cnt   <= '0;
                  r_sq    <= SQW'(w_acc_next);
                  r_zero  <= w_acc_next == '0;
                  r_rem   <= '0;
                  r_root  <= '0;
               end
            end
            SQRT: begin
               r_sq   <= r_sq << 2;
               r_rem  <= w_ge ? RW'(w_rem_sh - w_trial) : RW'(w_rem_sh);
               r_root <= {r_root[RW-2:0], w_ge};
               r_cnt  <= r_cnt + 1'b1;
               if (r_cnt == CW'(RW - 1)) begin
                  r_state <= DIV;
                  r_cnt   <= '0;
               end
            end
            DIV: begin
               r_cnt <= r_cnt + 1'b1;
               if (w_done) begin
                  r_data[r_ch*DATAWIDTH +: DATAWIDTH] <= w_q;
                  r_ch <= r_ch + 1'b1;
               end
               if (r_cnt == CW'(NUM_CHANNELS * DATAWIDTH)) begin
                  r_state <= HOLD;
                  r_valid <= 1'b1;
                  r_norm  <= r_root;
                  r_ozero <= r_zero;
               end
            end
            HOLD: if (o_ready) begin
               r_state <= IDLE;
               r_valid <= 1'b0;
            end
            default: r_state <= IDLE;
         endcase
   assign i_ready = r_state == IDLE;
   assign o_valid = r_valid;
   assign o_data  = r_data;
   assign o_norm  = r_norm;
   assign o_zero  = r_ozero;
endmodule

// File: tb/tb_vec_normalizer.sv
// tb_vec_normalizer: directed self-checking bench for vec_normalizer at default parameters
module tb_vec_normalizer;
   localparam int DW = 16;
   localparam int N  = 4;
   localparam int RW = 17;
   localparam int L  = 86;
   localparam logic [63:0] V_ONES = 64'h0100_0100_0100_0100;
   localparam logic [63:0] V_34   = 64'h0000_0000_0400_0300;
   localparam logic [63:0] V_MAX  = 64'h0000_0000_0000_FFFF;
   logic clk = 1'b0, rst = 1'b0, i_valid = 1'b0, o_ready = 1'b0;
   logic i_ready, o_valid, o_zero;
   logic [N*DW-1:0] i_data = '0, o_data, held_data;
   logic [RW-1:0] o_norm;
   int n_cmp = 0, n_bad = 0, cyc, seen;
   vec_normalizer #(.DATAWIDTH(DW), .FRAC_BITS(8), .NUM_CHANNELS(N), .INSTANCE_ID(3)) dut (
      .clk(clk), .rst(rst), .i_valid(i_valid), .i_ready(i_ready), .i_data(i_data),
      .o_valid(o_valid), .o_ready(o_ready), .o_data(o_data), .o_norm(o_norm), .o_zero(o_zero)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask
   task automatic send(input logic [63:0] v);
      @(negedge clk);
      chk("i_ready_before_send", 64'(i_ready), 64'd1);
      i_data  = v;
      i_valid = 1'b1;
      @(posedge clk);
      #1;
      i_valid = 1'b0;
      i_data  = {$urandom, $urandom};
   endtask
   task automatic wait_valid(output int n);
      n = 0;
      while (!o_valid && n < 200) begin
         @(posedge clk);
         #1;
         n++;
      end
   endtask
   task automatic take;
      @(negedge clk);
      o_ready = 1'b1;
      @(posedge clk);
      #1;
      o_ready = 1'b0;
      chk("i_ready_after_handshake", 64'(i_ready), 64'd1);
      chk("o_valid_after_handshake", 64'(o_valid), 64'd0);
   endtask
   task automatic run(input string tag, input logic [63:0] v, input logic [63:0] exp_data,
                      input logic [63:0] exp_norm, input logic exp_zero);
      send(v);
      chk({tag, "_no_early_valid"}, 64'(o_valid), 64'd0);
      wait_valid(cyc);
      chk({tag, "_latency"}, 64'(cyc), 64'(L));
      chk({tag, "_data"}, o_data, exp_data);
      chk({tag, "_norm"}, 64'(o_norm), exp_norm);
      chk({tag, "_zero"}, 64'(o_zero), 64'(exp_zero));
      take;
   endtask
   initial begin
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_i_ready", 64'(i_ready), 64'd1);
      chk("rst_o_valid", 64'(o_valid), 64'd0);
      chk("rst_o_data", o_data, 64'd0);
      chk("rst_o_norm", 64'(o_norm), 64'd0);
      chk("rst_o_zero", 64'(o_zero), 64'd0);
      rst = 1'b1;
      run("ones", V_ONES, 64'h0080_0080_0080_0080, 64'h200, 1'b0);
      run("v34", V_34, 64'h0000_0000_00CC_0099, 64'h500, 1'b0);
      run("zero", 64'd0, 64'd0, 64'd0, 1'b1);
      run("max", V_MAX, 64'h0000_0000_0000_0100, 64'hFFFF, 1'b0);
      send(V_ONES);
      wait_valid(cyc);
      chk("hold_latency", 64'(cyc), 64'(L));
      held_data = o_data;
      @(negedge clk);
      i_data  = V_34;
      i_valid = 1'b1;
      for (int k = 0; k < 10; k++) begin
         @(posedge clk);
         #1;
         chk("hold_o_valid", 64'(o_valid), 64'd1);
         chk("hold_o_data", o_data, 64'h0080_0080_0080_0080);
         chk("hold_o_norm", 64'(o_norm), 64'h200);
         chk("hold_i_ready", 64'(i_ready), 64'd0);
      end
      chk("hold_data_stable", o_data, held_data);
      @(negedge clk);
      o_ready = 1'b1;
      @(posedge clk);
      #1;
      o_ready = 1'b0;
      chk("b2b_i_ready_next", 64'(i_ready), 64'd1);
      chk("b2b_o_valid_low", 64'(o_valid), 64'd0);
      @(posedge clk);
      #1;
      i_valid = 1'b0;
      i_data  = '0;
      chk("b2b_accepted", 64'(i_ready), 64'd0);
      wait_valid(cyc);
      chk("b2b_latency", 64'(cyc), 64'(L));
      chk("b2b_data", o_data, 64'h0000_0000_00CC_0099);
      chk("b2b_norm", 64'(o_norm), 64'h500);
      take;
      send(V_ONES);
      repeat (20) @(posedge clk);
      #1;
      rst = 1'b0;
      #2;
      chk("abort_async_o_valid", 64'(o_valid), 64'd0);
      chk("abort_async_i_ready", 64'(i_ready), 64'd1);
      chk("abort_async_o_norm", 64'(o_norm), 64'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst  = 1'b1;
      seen = 0;
      for (int k = 0; k < 100; k++) begin
         @(posedge clk);
         #1;
         if (o_valid) seen++;
      end
      chk("abort_no_valid", 64'(seen), 64'd0);
      run("after_abort", V_ONES, 64'h0080_0080_0080_0080, 64'h200, 1'b0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
